// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round controller: owns the state register and round counter,
// and drives an external combinational round datapath and key schedule.
// Optional macro AES_ROUND_CTRL_FLUSH_EN adds a synchronous flush input.
module aes_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [127:0] out_data,
    input  logic         out_ready,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic [127:0] rnd_state,
    output logic         rnd_last,
    input  logic [127:0] rnd_result
`ifdef AES_ROUND_CTRL_FLUSH_EN
    ,
    input  logic         flush
`endif
);

    localparam logic [3:0] NrCnt = 4'(NR);

    typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] data_q, data_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         flush_w;

`ifdef AES_ROUND_CTRL_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= StIdle;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        unique case (fsm_q)
            StIdle: begin
                // Initial AddRoundKey with round key 0 happens on acceptance.
                if (in_valid && in_ready) begin
                    data_d = in_data ^ rk;
                    cnt_d  = 4'd1;
                    fsm_d  = StRound;
                end
            end
            StRound: begin
                data_d = rnd_result;
                if (rnd_last) begin
                    cnt_d = '0;
                    fsm_d = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    fsm_d = StIdle;
                end
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase
        if (flush_w && (fsm_q != StIdle)) begin
            fsm_d  = StIdle;
            data_d = '0;
            cnt_d  = '0;
        end
    end

    always_comb begin
        in_ready  = (fsm_q == StIdle) && !flush_w;
        out_valid = (fsm_q == StDone);
        out_data  = data_q;
        rnd_state = data_q;
        rk_idx    = (fsm_q == StRound) ? cnt_q : 4'd0;
        rnd_last  = (fsm_q == StRound) && (cnt_q == NrCnt);
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed and randomized bench for aes_round_ctrl with a reference AES-128
// round datapath and key schedule for key 000102030405060708090a0b0c0d0e0f.
module tb_aes_round_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_ready;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic [127:0] rnd_state;
    logic         rnd_last;
    logic [127:0] rnd_result;
`ifdef AES_ROUND_CTRL_FLUSH_EN
    logic         flush;
`endif

    int checks;
    int failures;

    logic [7:0]   sbox_t [256];
    logic [127:0] rks [11];

    localparam logic [127:0] Key = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] Pt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PtA = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] PtB = 128'hdeadbeef0123456789abcdeffedcba98;

    aes_round_ctrl #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .rk_idx     (rk_idx),
        .rk         (rk),
        .rnd_state  (rnd_state),
        .rnd_last   (rnd_last),
        .rnd_result (rnd_result)
`ifdef AES_ROUND_CTRL_FLUSH_EN
        ,
        .flush      (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   m [4];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) b[4*c+w] = a[4*((c+w)%4)+w];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                m[0] = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
                m[1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
                m[2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
                m[3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
                for (int w = 0; w < 4; w++) b[4*c+w] = m[w];
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r ^ k;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] p);
        logic [127:0] s;
        s = p ^ rks[0];
        for (int r = 1; r <= 10; r++) s = aes_rnd(s, rks[r], r == 10);
        return s;
    endfunction

    always_comb begin
        rk = '0;
        if (rk_idx <= 4'd10) rk = rks[rk_idx];
    end

    always_comb begin
        rnd_result = aes_rnd(rnd_state, rk, rnd_last);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accepts one block from IDLE and checks latency and ciphertext.
    task automatic run_block(input string tag, input logic [127:0] p);
        int lat;
        in_valid  = 1'b1;
        in_data   = p;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'd11);
        chk({tag, "_ct"}, out_data, aes_enc(p));
        @(negedge clk);
    endtask

    initial begin
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rcon;
        logic [7:0]   inv;
        logic [127:0] expq [$];
        logic [127:0] exp_ct;
        int           acc;
        int           got;
        int           cyc;
        int           ov_seen;
        int           m;

        checks   = 0;
        failures = 0;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int i = 0; i < 4; i++) w[i] = Key[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t    = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef AES_ROUND_CTRL_FLUSH_EN
        flush     = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_rk_idx", rk_idx, 0);
        chk("rst_rnd_last", rnd_last, 0);
        chk("rst_rnd_state", rnd_state, 0);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer vector with per-cycle round-key index and latency.
        chk("kat_idle_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = Pt;
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            chk($sformatf("kat_rk_idx_%0d", k), rk_idx, 128'(k));
            chk($sformatf("kat_rnd_last_%0d", k), rnd_last, (k == 10) ? 1 : 0);
            chk($sformatf("kat_in_ready_%0d", k), in_ready, 0);
            chk($sformatf("kat_out_valid_%0d", k), out_valid, 0);
        end
        @(negedge clk);
        chk("kat_out_valid", out_valid, 1);
        chk("kat_out_data", out_data, Ct);
        chk("kat_rnd_state", rnd_state, Ct);
        chk("kat_rk_idx_done", rk_idx, 0);
        @(negedge clk);
        chk("kat_out_valid_drop", out_valid, 0);
        chk("kat_in_ready_back", in_ready, 1);

        // Output stall with in_valid asserted and junk data while busy.
        in_valid  = 1'b1;
        in_data   = Pt;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 2; k <= 11; k++) @(negedge clk);
        in_valid = 1'b1;
        in_data  = PtB;
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("stall_out_valid_%0d", j), out_valid, 1);
            chk($sformatf("stall_out_data_%0d", j), out_data, Ct);
            chk($sformatf("stall_in_ready_%0d", j), in_ready, 0);
            if (j < 5) @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_out_valid", out_valid, 0);
        chk("stall_release_in_ready", in_ready, 1);

        // Back-to-back blocks with in_valid held high.
        in_valid  = 1'b1;
        in_data   = PtA;
        out_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            if (n == 1) in_data = PtB;
            if (n == 13) in_valid = 1'b0;
            m = n % 12;
            chk($sformatf("b2b_rk_idx_%0d", n), rk_idx, (m >= 1 && m <= 10) ? 128'(m) : 0);
            chk($sformatf("b2b_in_ready_%0d", n), in_ready, (m == 0) ? 1 : 0);
            chk($sformatf("b2b_out_valid_%0d", n), out_valid, (m == 11) ? 1 : 0);
            if (m == 11) chk($sformatf("b2b_ct_%0d", n), out_data, aes_enc(n < 12 ? PtA : PtB));
            @(negedge clk);
        end
        chk("b2b_end_in_ready", in_ready, 1);

        // Reset in the middle of round 5 discards the block.
        in_valid = 1'b1;
        in_data  = PtA;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 2; k <= 5; k++) @(negedge clk);
        chk("abort_rk_idx_5", rk_idx, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_rk_idx", rk_idx, 0);
        ov_seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        chk("abort_no_out_valid", 128'(ov_seen), 0);
        run_block("after_abort", PtB);

`ifdef AES_ROUND_CTRL_FLUSH_EN
        in_valid  = 1'b1;
        in_data   = PtA;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 2; k <= 11; k++) @(negedge clk);
        chk("flush_pre_out_valid", out_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_data", out_data, 0);
        chk("flush_in_ready", in_ready, 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("flush_idle_block", in_ready, 0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_idle_stays", in_ready, 1);
        chk("flush_idle_rk_idx", rk_idx, 0);
`endif

        // Random handshake traffic against the reference encryptor.
        acc = 0;
        got = 0;
        cyc = 0;
        while ((acc < 1000 || expq.size() != 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (acc < 1000) && ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                got++;
                if (expq.size() == 0) begin
                    chk("rand_spurious_out", out_valid, 0);
                end else begin
                    exp_ct = expq.pop_front();
                    chk($sformatf("rand_ct_%0d", got), out_data, exp_ct);
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(aes_enc(in_data));
                acc++;
            end
        end
        in_valid = 1'b0;
        chk("rand_in_count", 128'(acc), 1000);
        chk("rand_out_count", 128'(got), 1000);
        chk("rand_not_timed_out", (cyc < 60000) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES rounds (AES-128 only).
REQ-002 SHALL have ports as listed:
  clk  input  1  single clock; all state changes on rising edge
  rst  input  1  synchronous, active-high reset
  in_valid  input  1  plaintext block offered
  in_data  input  128  plaintext, byte 0 in [127:120]
  in_ready  output  1  controller can accept a block
  out_valid  output  1  ciphertext available
  out_data  output  128  ciphertext
  out_ready  input  1  consumer accepts ciphertext
  rk_idx  output  4  round-key index requested from key schedule
  rk  input  128  round key for rk_idx, combinational, same cycle
  rnd_state  output  128  state presented to external round datapath
  rnd_last  output  1  final round; datapath bypasses MixColumns
  rnd_result  input  128  combinational datapath output: SubBytes, ShiftRows, MixColumns unless rnd_last, AddRoundKey(rk)
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 SHALL implement FSM states IDLE, ROUND, DONE.
REQ-005 IDLE: in_ready=1, rk_idx=0; on in_valid&in_ready, state_reg <= in_data ^ rk, round_cnt <= 1, go to ROUND.
REQ-006 ROUND: in_ready=0, rk_idx=round_cnt, rnd_state=state_reg, each cycle state_reg <= rnd_result, round_cnt increments.
REQ-007 rnd_last SHALL be 1 only in ROUND with round_cnt==NR; that cycle SHALL transition to DONE.
REQ-008 DONE: out_valid=1, out_data=state_reg, held stable until out_valid&out_ready; then go to IDLE next cycle.
REQ-009 Latency: out_valid SHALL rise exactly NR+1 cycles after the accepting edge (11 for NR=10); throughput one block per NR+2 cycles with out_ready held high.
REQ-010 in_ready SHALL be 0 in ROUND and DONE; in_valid there is ignored, in_data never sampled.
REQ-011 out_data and rnd_state SHALL both equal state_reg at all times; rnd_last=0 outside ROUND.
REQ-012 round_cnt SHALL be 4 bits, never exceed NR, and be 0 in IDLE/DONE.
REQ-013 out_ready deasserted in DONE SHALL stall indefinitely with no state change.

Reset
REQ-014 rst=1 at an edge SHALL force IDLE, state_reg=0, round_cnt=0, from any state including mid-ROUND; the in-flight block is discarded, no out_valid.
REQ-015 Outputs after reset: in_ready=1, out_valid=0, out_data=0, rk_idx=0, rnd_last=0, rnd_state=0.
REQ-016 rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-017 Macro AES_ROUND_CTRL_FLUSH_EN defined: extra input port flush (1 bit); flush=1 at an edge in ROUND or DONE SHALL return to IDLE, clear state_reg and round_cnt, and suppress/withdraw out_valid; in IDLE it SHALL block acceptance that cycle; rst still overrides.
REQ-018 Macro undefined: no flush port, behaviour exactly REQ-004..REQ-016.

Verification (bench supplies reference round datapath and key schedule, key 000102030405060708090a0b0c0d0e0f)
REQ-019 Plaintext 00112233445566778899aabbccddeeff, out_ready=1 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after accept, held 1 cycle.
REQ-020 Same vector, out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0 throughout, release completes the handshake, in_ready=1 next cycle.
REQ-021 Back-to-back: in_valid held high with two blocks, out_ready=1 -> second accepted 12 cycles after first, both ciphertexts correct; rk_idx sequence 0,1..10 per block.
REQ-022 rst pulsed at round_cnt=5 -> next cycle IDLE, in_ready=1, out_valid never asserts for the aborted block; a following block encrypts correctly.
REQ-023 With AES_ROUND_CTRL_FLUSH_EN: flush during DONE with out_ready=0 -> out_valid=0 next cycle, state_reg=0; without the macro the build has no flush port.
REQ-024 Random in_valid/out_ready toggling, 1000 blocks -> every ciphertext matches model, no block lost or duplicated.
